// File: rtl/bcd_pkg.sv
// Shared types, constants and digit helpers for the BCD rounding engine.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } bcd_round_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
    localparam logic [3:0] BCD_ROUND_THRESH = 4'd5;

    function automatic logic bcd_digit_valid(input logic [3:0] digit);
        return digit <= BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// Single BCD digit plus carry-in, modulo 10, with carry-out.
module bcd_digit_inc
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [4:0] raw;

    always_comb begin
        raw       = {1'b0, digit} + {4'b0000, carry_in};
        carry_out = raw > {1'b0, BCD_DIGIT_MAX};
        sum       = carry_out ? 4'(raw - 5'd10) : raw[3:0];
    end

endmodule

// File: rtl/bcd_round_n.sv
// N-digit BCD round-half-up engine, carry rippled one digit per clock.
// Build option: BCD_ROUND_SAT_EN saturates the result to all 9s on overflow.
module bcd_round_n
    import bcd_pkg::*;
#(
    parameter  int N_DIGITS = 6,
    localparam int DW       = 4 * N_DIGITS,
    localparam int PW       = $clog2(N_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] bcd_in,
    input  logic [PW-1:0] drop_digits,
    output logic [DW-1:0] bcd_out,
    output logic          overflow,
    output logic          bcd_err,
    output logic          busy,
    output logic          done
);

`ifdef BCD_ROUND_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [DW-1:0] ALL_NINES = {N_DIGITS{4'h9}};
    localparam logic [PW-1:0] D_MAX     = PW'(N_DIGITS);
    localparam logic [PW-1:0] I_LAST    = PW'(N_DIGITS - 1);

    bcd_round_state_t state, state_n;
    logic [PW-1:0]    idx, idx_n, d_cl;
    logic [DW-1:0]    out_n, masked;
    logic             ovf_n, err_n;
    logic             round_bit, any_bad, accept;
    logic [3:0]       cur, inc_sum;
    logic             inc_carry;

    assign accept = start && (state != ROUND);
    assign busy   = (state == ROUND);
    assign done   = (state == DONE);

    // Capture-time view of the request: clamp, mask, round bit, validity.
    always_comb begin
        d_cl      = (drop_digits > D_MAX) ? D_MAX : drop_digits;
        masked    = bcd_in;
        round_bit = 1'b0;
        any_bad   = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (PW'(j) < d_cl)
                masked[4*j +: 4] = 4'd0;
            if (PW'(j + 1) == d_cl && bcd_in[4*j +: 4] >= BCD_ROUND_THRESH)
                round_bit = 1'b1;
            if (!bcd_digit_valid(bcd_in[4*j +: 4]))
                any_bad = 1'b1;
        end
    end

    always_comb begin
        cur = 4'd0;
        for (int j = 0; j < N_DIGITS; j++)
            if (idx == PW'(j))
                cur = bcd_out[4*j +: 4];
    end

    bcd_digit_inc u_inc (
        .digit     (cur),
        .carry_in  (1'b1),
        .sum       (inc_sum),
        .carry_out (inc_carry)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        out_n   = bcd_out;
        ovf_n   = overflow;
        err_n   = bcd_err;
        unique case (state)
            ROUND: begin
                for (int j = 0; j < N_DIGITS; j++)
                    if (idx == PW'(j))
                        out_n[4*j +: 4] = inc_sum;
                if (!inc_carry) begin
                    state_n = DONE;
                end else if (idx == I_LAST) begin
                    state_n = DONE;
                    ovf_n   = 1'b1;
                    if (SAT_EN)
                        out_n = ALL_NINES;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = state;
        endcase
        if (accept) begin
            ovf_n = 1'b0;
            err_n = 1'b0;
            idx_n = d_cl;
            if (any_bad) begin
                err_n   = 1'b1;
                out_n   = '0;
                state_n = DONE;
            end else if (!round_bit) begin
                out_n   = masked;
                state_n = DONE;
            end else if (d_cl == D_MAX) begin
                ovf_n   = 1'b1;
                out_n   = SAT_EN ? ALL_NINES : '0;
                state_n = DONE;
            end else begin
                out_n   = masked;
                state_n = ROUND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            bcd_err  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            bcd_out  <= out_n;
            overflow <= ovf_n;
            bcd_err  <= err_n;
        end
    end

endmodule
